// File: rtl/rom_fetch_pkg.sv
// rom_fetch_pkg: shared constants for the ROM fetch master and its wait timer
package rom_fetch_pkg;
    localparam int CNT_W = 4;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACC_LO = 3'd1;
    localparam logic [2:0] ST_REC_LO = 3'd2;
    localparam logic [2:0] ST_ACC_HI = 3'd3;
    localparam logic [2:0] ST_REC_HI = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;
endpackage

// File: rtl/rom_wait_timer.sv
// rom_wait_timer: 4-bit phase timer; done is high in the cycle whose closing edge ends the phase
module rom_wait_timer
    import rom_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic [CNT_W-1:0] length,
    output logic             done
);
    logic [CNT_W-1:0] cnt;
    assign done = en && (cnt == length - CNT_W'(1));
    // count while enabled, restart on start or at the terminal edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (start || done) cnt <= '0;
        else if (en) cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/rom_fetch_master.sv
// rom_fetch_master: 32-bit fetch over a 16-bit async ROM bus; optional ROM_FETCH_LASTADDR_CACHE_EN
module rom_fetch_master
    import rom_fetch_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_BITS      = 12,
    parameter int WAIT_CYCLES    = 6,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_BITS-1:0]    req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    mem_ce_n,
    output logic                    mem_oe_n,
    output logic [ADDR_BITS:0]      mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_data
);
    logic [2:0] state;
    logic acc, busy, tdone, hit;
    logic [2*DATA_WIDTH-1:0] hit_data;
    assign acc  = (state == ST_ACC_LO) || (state == ST_ACC_HI);
    assign busy = acc || (state == ST_REC_LO) || (state == ST_REC_HI);
    rom_wait_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (state == ST_IDLE),
        .en     (busy),
        .length (acc ? CNT_W'(WAIT_CYCLES) : CNT_W'(RECOVER_CYCLES)),
        .done   (tdone)
    );
`ifdef ROM_FETCH_LASTADDR_CACHE_EN
    logic                    cache_valid;
    logic [ADDR_BITS-1:0]    cache_tag;
    logic [2*DATA_WIDTH-1:0] cache_data;
    assign hit      = cache_valid && (cache_tag == req_addr);
    assign hit_data = cache_data;
    // remember the most recently completed bus fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else if (state == ST_REC_HI && tdone) begin
            cache_valid <= 1'b1;
            cache_tag   <= mem_addr[ADDR_BITS:1];
            cache_data  <= rsp_data;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif
    // fetch sequencer: two timed halfword accesses, each followed by a bus recovery gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid && req_ready) begin
                    req_ready <= 1'b0;
                    if (hit) begin
                        rsp_data  <= hit_data;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        mem_addr <= {req_addr, HALF_LO};
                        mem_ce_n <= 1'b0;
                        mem_oe_n <= 1'b0;
                        state    <= ST_ACC_LO;
                    end
                end
                ST_ACC_LO: if (tdone) begin
                    rsp_data[DATA_WIDTH-1:0] <= mem_data;
                    mem_ce_n <= 1'b1;
                    mem_oe_n <= 1'b1;
                    state    <= ST_REC_LO;
                end
                ST_REC_LO: if (tdone) begin
                    mem_addr[0] <= HALF_HI;
                    mem_ce_n    <= 1'b0;
                    mem_oe_n    <= 1'b0;
                    state       <= ST_ACC_HI;
                end
                ST_ACC_HI: if (tdone) begin
                    rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= mem_data;
                    mem_ce_n <= 1'b1;
                    mem_oe_n <= 1'b1;
                    state    <= ST_REC_HI;
                end
                ST_REC_HI: if (tdone) begin
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rom_fetch_master.sv
// tb_rom_fetch_master: directed bench for rom_fetch_master against a slow async ROM model
module tb_rom_fetch_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, rsp_ready = 1'b0;
    logic [11:0] req_addr = '0;
    logic        req_ready, rsp_valid, mem_ce_n, mem_oe_n;
    logic [31:0] rsp_data;
    logic [12:0] mem_addr;
    logic [15:0] mem_data;
    logic        f_req_valid = 1'b0, f_rsp_ready = 1'b1;
    logic [11:0] f_req_addr = '0;
    logic        f_req_ready, f_rsp_valid, f_ce_n, f_oe_n;
    logic [31:0] f_rsp_data;
    logic [12:0] f_mem_addr;
    logic [15:0] f_mem_data;
    int n_chk = 0, n_pass = 0;
    int low_cnt = 0, low_run = 0, high_run = 0, addr_viol = 0, oe_viol = 0;
    logic prev_ce = 1'b1;
    logic [12:0] prev_addr = '0;
    int runs[$];
    int gaps[$];

    always #5 clk = ~clk;

    rom_fetch_master dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .mem_ce_n(mem_ce_n),
        .mem_oe_n(mem_oe_n), .mem_addr(mem_addr), .mem_data(mem_data)
    );
    rom_fetch_master #(.WAIT_CYCLES(1), .RECOVER_CYCLES(1)) dut_fast (
        .clk(clk), .reset(reset), .req_valid(f_req_valid), .req_ready(f_req_ready), .req_addr(f_req_addr),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data), .mem_ce_n(f_ce_n),
        .mem_oe_n(f_oe_n), .mem_addr(f_mem_addr), .mem_data(f_mem_data)
    );

    function automatic logic [15:0] rom(input logic [12:0] h);
        return (h == 13'h014) ? 16'h1234 : (h == 13'h015) ? 16'hABCD : (16'h5A5A ^ {3'b0, h});
    endfunction
    function automatic logic [31:0] word(input logic [11:0] a);
        return {rom({a, 1'b1}), rom({a, 1'b0})};
    endfunction

    // responder only drives valid data once CE_n/OE_n have been low for 6 cycles
    always @(posedge clk) low_cnt <= mem_ce_n ? 0 : low_cnt + 1;
    assign mem_data   = (!mem_ce_n && !mem_oe_n && low_cnt >= 5) ? rom(mem_addr) : 16'hDEAD;
    assign f_mem_data = (!f_ce_n && !f_oe_n) ? rom(f_mem_addr) : 16'hDEAD;

    // bus monitor: CE_n low/high run lengths, address stability during an access, OE_n tracking CE_n
    always @(negedge clk) begin
        prev_ce   <= mem_ce_n;
        prev_addr <= mem_addr;
        if (!mem_ce_n && !prev_ce && mem_addr !== prev_addr) addr_viol <= addr_viol + 1;
        if (mem_oe_n !== mem_ce_n) oe_viol <= oe_viol + 1;
        low_run  <= mem_ce_n ? 0 : low_run + 1;
        high_run <= mem_ce_n ? high_run + 1 : 0;
        if (mem_ce_n && !prev_ce) runs.push_back(low_run);
        if (!mem_ce_n && prev_ce) gaps.push_back(high_run);
    end

    task automatic fetch(input logic [11:0] a, output int lat, output logic [31:0] d);
        int w = 0;
        while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        d = rsp_data;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else n_pass++;
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_chk++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
        n_chk++; if ({mem_ce_n, mem_oe_n} !== 2'b11) $display("FAIL reset_ce_oe: got %b want 11", {mem_ce_n, mem_oe_n}); else n_pass++;
        n_chk++; if (mem_addr !== 13'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        int lat;
        logic [31:0] d;
        runs.delete(); gaps.delete();
        fetch(12'h00A, lat, d);
        n_chk++; if (lat !== 15) $display("FAIL single_latency: got %0d want 15", lat); else n_pass++;
        n_chk++; if (d !== 32'hABCD1234) $display("FAIL single_data: got %h want abcd1234", d); else n_pass++;
        n_chk++; if (runs.size() !== 2 || runs[0] !== 6 || runs[1] !== 6)
            $display("FAIL single_ce_low: got %0d runs (%0d,%0d) want 2 runs (6,6)", runs.size(), runs[0], runs[1]); else n_pass++;
        n_chk++; if (gaps.size() !== 2 || gaps[1] !== 1)
            $display("FAIL single_ce_gap: got %0d gaps, middle %0d want 2 gaps, middle 1", gaps.size(), gaps[1]); else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int lat, bad = 0;
        logic [31:0] d;
        fetch(12'h003, lat, d);
        n_chk++; if (d !== word(12'h003)) $display("FAIL bp_data: got %h want %h", d, word(12'h003)); else n_pass++;
        runs.delete();
        req_valid = 1'b1;
        req_addr  = 12'h7FF;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== d || req_ready !== 1'b0 || mem_ce_n !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        n_chk++; if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad); else n_pass++;
        n_chk++; if (runs.size() !== 0) $display("FAIL bp_bus_idle: got %0d accesses want 0", runs.size()); else n_pass++;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_chk++; if ({rsp_valid, req_ready} !== 2'b01)
            $display("FAIL bp_release: got valid,ready=%b want 01", {rsp_valid, req_ready}); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat, bad = 0;
        logic [31:0] d;
        runs.delete(); gaps.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch(12'(i), lat, d);
            n_chk++; if (lat !== 15) $display("FAIL b2b_latency_%0d: got %0d want 15", i, lat); else n_pass++;
            n_chk++; if (d !== word(12'(i))) $display("FAIL b2b_data_%0d: got %h want %h", i, d, word(12'(i))); else n_pass++;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        foreach (runs[k]) if (runs[k] !== 6) bad++;
        n_chk++; if (runs.size() !== 6 || bad !== 0)
            $display("FAIL b2b_ce_runs: got %0d runs, %0d not 6 want 6 runs of 6", runs.size(), bad); else n_pass++;
        n_chk++; if (gaps.size() !== 6) $display("FAIL b2b_ce_gaps: got %0d high gaps want 6", gaps.size()); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [31:0] d;
        req_valid = 1'b1;
        req_addr  = 12'h005;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        n_chk++; if ({mem_ce_n, mem_addr[0]} !== 2'b01)
            $display("FAIL mid_in_acc_hi: got ce_n,half=%b want 01", {mem_ce_n, mem_addr[0]}); else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_chk++; if ({mem_ce_n, mem_oe_n, rsp_valid} !== 3'b110)
            $display("FAIL mid_async_release: got ce,oe,valid=%b want 110", {mem_ce_n, mem_oe_n, rsp_valid}); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        fetch(12'h005, lat, d);
        n_chk++; if (lat !== 15 || d !== word(12'h005))
            $display("FAIL mid_refetch: got lat %0d data %h want 15 %h", lat, d, word(12'h005)); else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_fast;
        int lat = 1;
        f_req_valid = 1'b1;
        f_req_addr  = 12'h00A;
        @(posedge clk); #1;
        f_req_valid = 1'b0;
        while (!f_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        n_chk++; if (lat !== 5) $display("FAIL fast_latency: got %0d want 5", lat); else n_pass++;
        n_chk++; if (f_rsp_data !== 32'hABCD1234) $display("FAIL fast_data: got %h want abcd1234", f_rsp_data); else n_pass++;
        @(posedge clk); #1;
    endtask

`ifdef ROM_FETCH_LASTADDR_CACHE_EN
    task automatic test_cache;
        int lat;
        logic [31:0] d;
        rsp_ready = 1'b1;
        fetch(12'h00A, lat, d);
        n_chk++; if (lat !== 15 || d !== 32'hABCD1234)
            $display("FAIL cache_fill: got lat %0d data %h want 15 abcd1234", lat, d); else n_pass++;
        @(posedge clk); #1;
        runs.delete();
        fetch(12'h00A, lat, d);
        n_chk++; if (lat !== 1 || d !== 32'hABCD1234)
            $display("FAIL cache_hit: got lat %0d data %h want 1 abcd1234", lat, d); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (runs.size() !== 0 || mem_ce_n !== 1'b1)
            $display("FAIL cache_hit_bus: got %0d accesses want 0", runs.size()); else n_pass++;
        fetch(12'h00B, lat, d);
        n_chk++; if (lat !== 15 || d !== word(12'h00B) || runs.size() !== 2)
            $display("FAIL cache_miss: got lat %0d data %h runs %0d want 15 %h 2", lat, d, runs.size(), word(12'h00B)); else n_pass++;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_fast();
`ifdef ROM_FETCH_LASTADDR_CACHE_EN
        test_cache();
`endif
        n_chk++; if (addr_viol !== 0) $display("FAIL addr_stable: got %0d changes during access want 0", addr_viol); else n_pass++;
        n_chk++; if (oe_viol !== 0) $display("FAIL oe_tracks_ce: got %0d differing cycles want 0", oe_viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
